// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: MIPS opcode/funct fields, ALU op and
// result-select codes, plus small lookup helpers used by the decoder.
package id_stage_pipe_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;

   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;

   localparam logic [7:0] ALUOP_NOP = 8'b00000000;
   localparam logic [7:0] ALUOP_AND = 8'b00100100;
   localparam logic [7:0] ALUOP_OR  = 8'b00100101;
   localparam logic [7:0] ALUOP_XOR = 8'b00100110;
   localparam logic [7:0] ALUOP_NOR = 8'b00100111;
   localparam logic [7:0] ALUOP_SLL = 8'b01111100;
   localparam logic [7:0] ALUOP_SRL = 8'b00000010;
   localparam logic [7:0] ALUOP_SRA = 8'b00000011;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;

   localparam logic [4:0] NOP_REG = 5'd0;

   function automatic logic [7:0] imm_aluop(input logic [5:0] op);
      case (op)
         OP_ANDI: imm_aluop = ALUOP_AND;
         OP_ORI:  imm_aluop = ALUOP_OR;
         OP_XORI: imm_aluop = ALUOP_XOR;
         default: imm_aluop = ALUOP_NOP;
      endcase
   endfunction

   function automatic logic [7:0] funct_aluop(input logic [5:0] fn);
      case (fn)
         FN_AND:  funct_aluop = ALUOP_AND;
         FN_OR:   funct_aluop = ALUOP_OR;
         FN_XOR:  funct_aluop = ALUOP_XOR;
         FN_NOR:  funct_aluop = ALUOP_NOR;
         FN_SLL:  funct_aluop = ALUOP_SLL;
         FN_SRL:  funct_aluop = ALUOP_SRL;
         FN_SRA:  funct_aluop = ALUOP_SRA;
         default: funct_aluop = ALUOP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// One operand port of the ID stage: immediate / zero-register / EX-MEM bypass
// selection, plus the hazard this port contributes to the stall request.
module id_fwd_mux
   import id_stage_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic              read,
   input  logic [REG_AW-1:0] addr,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_wreg,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              ex_is_load,
   input  logic              mem_wreg,
   input  logic [REG_AW-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] data,
   output logic              hazard
);

   localparam bit BYPASS = (FWD_EN != 0);

   logic ex_hit;
   logic mem_hit;
   logic live;

   always_comb begin
      ex_hit  = ex_wreg && (ex_wd == addr);
      mem_hit = mem_wreg && (mem_wd == addr);
      live    = read && (addr != REG_AW'(NOP_REG));

      data = rf_data;
      if (!read)
         data = imm;
      else if (addr == REG_AW'(NOP_REG))
         data = '0;
      else if (BYPASS && ex_hit && !ex_is_load)
         data = ex_wdata;
      else if (BYPASS && mem_hit)
         data = mem_wdata;

      // Without a bypass network any in-flight writer of this register must drain first.
      hazard = live && ((ex_hit && ex_is_load) || (!BYPASS && (ex_hit || mem_hit)));
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered MIPS decode stage: decodes logic/LUI/shift instructions, selects
// bypassed operands, stalls on load-use and holds the ID/EX register.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       pc_i,
   input  logic [31:0]       inst_i,
   output logic              reg1_read_o,
   output logic [REG_AW-1:0] reg1_addr_o,
   input  logic [DATA_W-1:0] reg1_data_i,
   output logic              reg2_read_o,
   output logic [REG_AW-1:0] reg2_addr_o,
   input  logic [DATA_W-1:0] reg2_data_i,
   input  logic              ex_wreg_i,
   input  logic [REG_AW-1:0] ex_wd_i,
   input  logic [DATA_W-1:0] ex_wdata_i,
   input  logic              ex_is_load_i,
   input  logic              mem_wreg_i,
   input  logic [REG_AW-1:0] mem_wd_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   input  logic              flush_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        aluop_o,
   output logic [2:0]        alusel_o,
   output logic [DATA_W-1:0] reg1_o,
   output logic [DATA_W-1:0] reg2_o,
   output logic [REG_AW-1:0] wd_o,
   output logic              wreg_o,
   output logic [31:0]       pc_o,
   output logic              inst_invalid_o,
   output logic              stallreq_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        shamt;
   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic [REG_AW-1:0] dec_wd;
   logic              dec_wreg;
   logic              dec_invalid;
   logic [DATA_W-1:0] imm1;
   logic [DATA_W-1:0] imm2;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic              haz1;
   logic              haz2;
   logic              load;

   assign op          = inst_i[31:26];
   assign funct       = inst_i[5:0];
   assign shamt       = inst_i[10:6];
   assign reg1_addr_o = REG_AW'(inst_i[25:21]);
   assign reg2_addr_o = REG_AW'(inst_i[20:16]);

   always_comb begin
      dec_aluop   = ALUOP_NOP;
      dec_alusel  = SEL_NOP;
      dec_wd      = REG_AW'(NOP_REG);
      dec_wreg    = 1'b0;
      dec_invalid = 1'b1;
      reg1_read_o = 1'b0;
      reg2_read_o = 1'b0;
      imm1        = '0;
      imm2        = '0;
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec_aluop   = imm_aluop(op);
            dec_alusel  = SEL_LOGIC;
            dec_wd      = REG_AW'(inst_i[20:16]);
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
            reg1_read_o = 1'b1;
            imm2        = DATA_W'(inst_i[IMM_W-1:0]);
         end
         // Port 1 stays unread so its immediate (zero) stands in for $0.
         OP_LUI: begin
            dec_aluop   = ALUOP_OR;
            dec_alusel  = SEL_LOGIC;
            dec_wd      = REG_AW'(inst_i[20:16]);
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
            imm2        = DATA_W'({inst_i[IMM_W-1:0], {IMM_W{1'b0}}});
         end
         OP_SPECIAL: begin
            case (funct)
               FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                  if (shamt == 5'd0) begin
                     dec_aluop   = funct_aluop(funct);
                     dec_alusel  = SEL_LOGIC;
                     dec_wd      = REG_AW'(inst_i[15:11]);
                     dec_wreg    = 1'b1;
                     dec_invalid = 1'b0;
                     reg1_read_o = 1'b1;
                     reg2_read_o = 1'b1;
                  end
               end
               FN_SLL, FN_SRL, FN_SRA: begin
                  dec_aluop   = funct_aluop(funct);
                  dec_alusel  = SEL_SHIFT;
                  dec_wd      = REG_AW'(inst_i[15:11]);
                  dec_wreg    = (inst_i != 32'd0);
                  dec_invalid = 1'b0;
                  reg2_read_o = 1'b1;
                  imm1        = DATA_W'(shamt);
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd1 (
      .read(reg1_read_o), .addr(reg1_addr_o), .imm(imm1), .rf_data(reg1_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
      .data(op1), .hazard(haz1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd2 (
      .read(reg2_read_o), .addr(reg2_addr_o), .imm(imm2), .rf_data(reg2_data_i),
      .ex_wreg(ex_wreg_i), .ex_wd(ex_wd_i), .ex_wdata(ex_wdata_i), .ex_is_load(ex_is_load_i),
      .mem_wreg(mem_wreg_i), .mem_wd(mem_wd_i), .mem_wdata(mem_wdata_i),
      .data(op2), .hazard(haz2)
   );

   // Handshake: an instruction transfers in on a cycle where in_valid && in_ready,
   // and out on a cycle where out_valid && out_ready; both sides hold while waiting.
   assign stallreq_o = in_valid && (haz1 || haz2);
   assign in_ready   = (!out_valid || out_ready) && !stallreq_o;
   assign load       = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid      <= 1'b0;
         aluop_o        <= ALUOP_NOP;
         alusel_o       <= SEL_NOP;
         reg1_o         <= '0;
         reg2_o         <= '0;
         wd_o           <= REG_AW'(NOP_REG);
         wreg_o         <= 1'b0;
         pc_o           <= 32'd0;
         inst_invalid_o <= 1'b0;
         stall_cnt_o    <= '0;
      end else begin
         if (flush_i || (out_ready && !load)) begin
            out_valid <= 1'b0;
            wreg_o    <= 1'b0;
            aluop_o   <= ALUOP_NOP;
            alusel_o  <= SEL_NOP;
         end else if (load) begin
            out_valid      <= 1'b1;
            aluop_o        <= dec_aluop;
            alusel_o       <= dec_alusel;
            reg1_o         <= op1;
            reg2_o         <= op2;
            wd_o           <= dec_wd;
            wreg_o         <= dec_wreg;
            pc_o           <= pc_i;
            inst_invalid_o <= dec_invalid;
         end
         if (stallreq_o && !flush_i && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: issued instructions push their expected ID/EX
// contents; a monitor pops and compares whenever EX consumes the register.
module tb_id_stage_pipe;

   localparam int EXP_W = 116;

   localparam logic [7:0] A_NOP = 8'h00;
   localparam logic [7:0] A_AND = 8'h24;
   localparam logic [7:0] A_OR  = 8'h25;
   localparam logic [7:0] A_XOR = 8'h26;
   localparam logic [7:0] A_NOR = 8'h27;
   localparam logic [7:0] A_SRA = 8'h03;
   localparam logic [2:0] S_NOP = 3'd0;
   localparam logic [2:0] S_LOG = 3'd1;
   localparam logic [2:0] S_SHF = 3'd2;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] pc_i, inst_i;
   logic        reg1_read_o, reg2_read_o;
   logic [4:0]  reg1_addr_o, reg2_addr_o;
   logic [31:0] reg1_data_i, reg2_data_i;
   logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        flush_i;
   logic        out_valid, out_ready;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] reg1_o, reg2_o, pc_o;
   logic [4:0]  wd_o;
   logic        wreg_o, inst_invalid_o, stallreq_o;
   logic [15:0] stall_cnt_o;

   logic        s_in_ready, s_r1rd, s_r2rd, s_out_valid, s_wreg, s_inv, s_stallreq;
   logic [4:0]  s_r1a, s_r2a, s_wd;
   logic [7:0]  s_aluop;
   logic [2:0]  s_alusel;
   logic [31:0] s_reg1, s_reg2, s_pc;
   logic [1:0]  s_cnt;

   logic [31:0] rf [32];
   logic [EXP_W-1:0] exp_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   assign reg1_data_i = rf[reg1_addr_o];
   assign reg2_data_i = rf[reg2_addr_o];

   id_stage_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
      .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
      .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
      .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
      .inst_invalid_o(inst_invalid_o), .stallreq_o(stallreq_o), .stall_cnt_o(stall_cnt_o)
   );

   id_stage_pipe #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_read_o(s_r1rd), .reg1_addr_o(s_r1a), .reg1_data_i(reg1_data_i),
      .reg2_read_o(s_r2rd), .reg2_addr_o(s_r2a), .reg2_data_i(reg2_data_i),
      .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i), .flush_i(flush_i),
      .out_valid(s_out_valid), .out_ready(out_ready), .aluop_o(s_aluop), .alusel_o(s_alusel),
      .reg1_o(s_reg1), .reg2_o(s_reg2), .wd_o(s_wd), .wreg_o(s_wreg), .pc_o(s_pc),
      .inst_invalid_o(s_inv), .stallreq_o(s_stallreq), .stall_cnt_o(s_cnt)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [EXP_W-1:0] mk_exp(input logic [7:0] aluop, input logic [2:0] alusel,
      input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
      input logic [31:0] pc, input logic inv, input logic chk_alu, input logic chk_ops);
      return {chk_alu, chk_ops, inv, pc, wreg, wd, r2, r1, alusel, aluop};
   endfunction

   // Driver
   task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [EXP_W-1:0] e, output int waited);
      pc_i = pc;
      inst_i = inst;
      in_valid = 1'b1;
      waited = -1;
      for (int n = 0; n < 20 && waited < 0; n++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            waited = n;
         end
      end
      if (waited < 0) begin
         total_cnt++;
         $display("FAIL accept_timeout: pc %h not accepted within 20 cycles", pc);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL mon_unexpected: output pc %h with no expected entry", pc_o);
         end else begin
            e = exp_q.pop_front();
            if (e[115]) begin
               check("mon_aluop", 32'(aluop_o), 32'(e[7:0]));
               check("mon_alusel", 32'(alusel_o), 32'(e[10:8]));
            end
            if (e[114]) begin
               check("mon_reg1", reg1_o, e[42:11]);
               check("mon_reg2", reg2_o, e[74:43]);
               check("mon_wd", 32'(wd_o), 32'(e[79:75]));
            end
            check("mon_wreg", 32'(wreg_o), 32'(e[80]));
            check("mon_pc", pc_o, e[112:81]);
            check("mon_invalid", 32'(inst_invalid_o), 32'(e[113]));
         end
      end
   end

   initial begin
      int w;
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | 32'(i));
      rst = 1'b1;
      in_valid = 1'b0; pc_i = '0; inst_i = '0;
      ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
      mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
      flush_i = 1'b0; out_ready = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_aluop", 32'(aluop_o), 0);
      check("rst_alusel", 32'(alusel_o), 0);
      check("rst_wd", 32'(wd_o), 0);
      check("rst_wreg", 32'(wreg_o), 0);
      check("rst_stall_cnt", 32'(stall_cnt_o), 0);
      rst = 1'b1;

      // ORI, R-type bypass priority, zero register, shift, LUI, NOR, invalid forms
      send(32'h100, 32'h3401_1100, mk_exp(A_OR, S_LOG, 0, 32'h1100, 1, 1, 32'h100, 0, 1, 1), w);
      ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hA;
      mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'hC;
      send(32'h104, 32'h0022_1825, mk_exp(A_OR, S_LOG, 32'hA, 32'hC, 3, 1, 32'h104, 0, 1, 1), w);
      mem_wd_i = 1; mem_wdata_i = 32'hB;
      send(32'h108, 32'h0022_1825, mk_exp(A_OR, S_LOG, 32'hA, 32'h1000_0002, 3, 1, 32'h108, 0, 1, 1), w);
      ex_wreg_i = 0;
      send(32'h10C, 32'h0022_1825, mk_exp(A_OR, S_LOG, 32'hB, 32'h1000_0002, 3, 1, 32'h10C, 0, 1, 1), w);
      ex_wreg_i = 1; ex_wd_i = 0; mem_wd_i = 0;
      send(32'h110, 32'h0002_1825, mk_exp(A_OR, S_LOG, 0, 32'h1000_0002, 3, 1, 32'h110, 0, 1, 1), w);
      ex_wd_i = 2; ex_wdata_i = 32'h8000_0000; mem_wreg_i = 0;
      send(32'h114, 32'h0002_48C3, mk_exp(A_SRA, S_SHF, 3, 32'h8000_0000, 9, 1, 32'h114, 0, 1, 1), w);
      ex_wreg_i = 0;
      send(32'h118, 32'h3C0A_ABCD, mk_exp(A_OR, S_LOG, 0, 32'hABCD_0000, 10, 1, 32'h118, 0, 1, 1), w);
      send(32'h11C, 32'h0022_5827, mk_exp(A_NOR, S_LOG, 32'h1000_0001, 32'h1000_0002, 11, 1, 32'h11C, 0, 1, 1), w);
      send(32'h120, 32'h0022_1865, mk_exp(A_NOP, S_NOP, 0, 0, 0, 0, 32'h120, 1, 1, 0), w);
      send(32'h124, 32'h0000_0000, mk_exp(A_NOP, S_NOP, 0, 0, 0, 0, 32'h124, 0, 0, 1), w);
      send(32'h128, 32'hFC00_0000, mk_exp(A_NOP, S_NOP, 0, 0, 0, 0, 32'h128, 1, 1, 0), w);

      // Load-use stall on XOR $5,$4,$6
      ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1;
      pc_i = 32'h12C; inst_i = 32'h0086_2826; in_valid = 1;
      @(negedge clk);
      check("lu_stallreq", 32'(stallreq_o), 1);
      check("lu_in_ready", 32'(in_ready), 0);
      check("lu_cnt_before", 32'(stall_cnt_o), 0);
      @(posedge clk);
      #1;
      check("lu_cnt_after", 32'(stall_cnt_o), 1);
      check("lu_sat_cnt", 32'(s_cnt), 1);
      check("lu_bubble", 32'(out_valid), 0);
      ex_is_load_i = 0; ex_wreg_i = 0;
      mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'h44;
      send(32'h12C, 32'h0086_2826, mk_exp(A_XOR, S_LOG, 32'h44, 32'h1000_0006, 5, 1, 32'h12C, 0, 1, 1), w);
      check("lu_resume_wait", 32'(w), 0);
      mem_wreg_i = 0;

      // Backpressure: XORI held for three cycles while ANDI waits
      @(posedge clk);
      #1;
      out_ready = 0;
      send(32'h130, 32'h3847_00FF, mk_exp(A_XOR, S_LOG, 32'h1000_0002, 32'hFF, 7, 1, 32'h130, 0, 1, 1), w);
      pc_i = 32'h134; inst_i = 32'h3068_F0F0; in_valid = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_reg2", reg2_o, 32'hFF);
         check("bp_wd", 32'(wd_o), 7);
         check("bp_aluop", 32'(aluop_o), 32'(A_XOR));
      end
      @(posedge clk);
      #1;
      out_ready = 1;
      send(32'h134, 32'h3068_F0F0, mk_exp(A_AND, S_LOG, 32'h1000_0003, 32'hF0F0, 8, 1, 32'h134, 0, 1, 1), w);
      check("bp_same_cycle_load", 32'(w), 0);

      // Flush of an incoming word, then of a held instruction
      @(posedge clk);
      #1;
      pc_i = 32'h138; inst_i = 32'h3401_1100; in_valid = 1; flush_i = 1;
      @(negedge clk);
      check("fl_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      flush_i = 0; in_valid = 0;
      check("fl_out_valid", 32'(out_valid), 0);
      check("fl_wreg", 32'(wreg_o), 0);
      out_ready = 0;
      send(32'h13C, 32'h3401_1100, mk_exp(A_OR, S_LOG, 0, 32'h1100, 1, 1, 32'h13C, 0, 1, 1), w);
      flush_i = 1;
      @(posedge clk);
      #1;
      flush_i = 0;
      void'(exp_q.pop_back());
      check("flh_out_valid", 32'(out_valid), 0);
      check("flh_wreg", 32'(wreg_o), 0);
      out_ready = 1;
      ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1;
      pc_i = 32'h12C; inst_i = 32'h0086_2826; in_valid = 1; flush_i = 1;
      @(posedge clk);
      #1;
      flush_i = 0; in_valid = 0;
      check("fl_stall_no_count", 32'(stall_cnt_o), 1);

      // Saturation and asynchronous reset mid-stall with a held instruction
      ex_is_load_i = 0; ex_wreg_i = 0; out_ready = 0;
      send(32'h140, 32'h3401_1100, mk_exp(A_OR, S_LOG, 0, 32'h1100, 1, 1, 32'h140, 0, 1, 1), w);
      ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1;
      pc_i = 32'h144; inst_i = 32'h0086_2826; in_valid = 1;
      repeat (4) @(posedge clk);
      #1;
      check("cnt_five", 32'(stall_cnt_o), 5);
      check("sat_cnt", 32'(s_cnt), 3);
      check("held_valid", 32'(out_valid), 1);
      @(negedge clk);
      #2 rst = 0;
      #1;
      check("ar_out_valid", 32'(out_valid), 0);
      check("ar_wreg", 32'(wreg_o), 0);
      check("ar_aluop", 32'(aluop_o), 0);
      check("ar_alusel", 32'(alusel_o), 0);
      check("ar_wd", 32'(wd_o), 0);
      check("ar_pc", pc_o, 0);
      check("ar_stall_cnt", 32'(stall_cnt_o), 0);
      check("ar_sat_cnt", 32'(s_cnt), 0);
      exp_q.delete();
      in_valid = 0; ex_wreg_i = 0; ex_is_load_i = 0;
      @(posedge clk);
      #1;
      rst = 1; out_ready = 1;
      send(32'h148, 32'h3401_1100, mk_exp(A_OR, S_LOG, 0, 32'h1100, 1, 1, 32'h148, 0, 1, 1), w);
      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
